planificador_necesidades: RTL and testbench

PLANIFICADOR_NECESIDADES -- requirements
Module: planificador_necesidades

---
 rtl/necesidades_pkg.sv | 19 +
 rtl/planificador_necesidades_divisor_tick.sv | 48 ++++
 rtl/planificador_necesidades.sv | 176 +++++++++++++++++
 tb/tb_planificador_necesidades.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/necesidades_pkg.sv
// Shared types and constants for the needs scheduler.
// Need indices, level bounds and the scheduler FSM state type.
package necesidades_pkg;

   typedef enum logic [1:0] {
      REPOSO,
      CONCEDER,
      ATENCION_5S
   } estado_t;

   localparam int IDX_ANIMO    = 0;
   localparam int IDX_ENERGIA  = 1;
   localparam int IDX_DESCANSO = 2;
   localparam int IDX_MEDICINA = 3;

   localparam logic [1:0] NIVEL_MAX = 2'd3;
   localparam logic [1:0] NIVEL_MIN = 2'd0;

endpackage

// File: rtl/planificador_necesidades_divisor_tick.sv
// Base tick divider with period select; a new period loads only at wrap.
// Test-mode period shortening exists only when MODO_TEST_EN is defined.
module divisor_tick
   import necesidades_pkg::*;
#(
   parameter int CICLOS_TICK = 50000000,
   parameter int TEST_DIV    = 10,
   localparam int W          = $clog2(CICLOS_TICK + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         test,
   output logic [W-1:0] periodo,
   output logic         tick
);

   localparam logic [W-1:0] P_NORM = W'(CICLOS_TICK);
   localparam logic [W-1:0] UNO    = W'(1);

   logic [W-1:0] cuenta;
   logic [W-1:0] sel;

`ifdef MODO_TEST_EN
   localparam int P_DIV = CICLOS_TICK / TEST_DIV;
   localparam logic [W-1:0] P_TEST = W'((P_DIV < 1) ? 1 : P_DIV);
   assign sel = test ? P_TEST : P_NORM;
`else
   localparam int unused_div = TEST_DIV;
   logic unused_test;
   assign unused_test = test;
   assign sel = P_NORM;
`endif

   assign tick = (cuenta >= periodo - UNO);

   always_ff @(posedge clk) begin
      if (rst) begin
         cuenta  <= '0;
         periodo <= sel;
      end else if (tick) begin
         cuenta  <= '0;
         periodo <= sel;
      end else begin
         cuenta  <= cuenta + UNO;
      end
   end

endmodule

// File: rtl/planificador_necesidades.sv
// Needs scheduler: round-robin decay, priority grants, 5 s attention window.
// Optional test-mode tick acceleration under macro MODO_TEST_EN.
module planificador_necesidades
   import necesidades_pkg::*;
#(
   parameter int CICLOS_TICK = 50000000,
   parameter int TICKS_DECAE = 10,
   parameter int TICKS_5S    = 5,
   parameter int TEST_DIV    = 10
) (
   input  logic       clk,
   input  logic       Bot_Reset,
   input  logic       Bot_Test,
   input  logic       Bot_Energia,
   input  logic       Bot_Medicina,
   input  logic       Entrada_Descanso,
   input  logic       Entrada_Animo,
   output logic [1:0] Nivel_Animo,
   output logic [1:0] Nivel_Energia,
   output logic [1:0] Nivel_Descanso,
   output logic [1:0] Nivel_Medicina,
   output logic       senal_5segEnergia,
   output logic       senal_5segMedicina,
   output logic       Alerta
);

   localparam int W   = $clog2(CICLOS_TICK + 1);
   localparam int DW  = $clog2(TICKS_DECAE + 1);
   localparam int C5W = $clog2(TICKS_5S + 1);
   localparam logic [W-1:0] UNO = W'(1);

   logic [W-1:0]     periodo;
   logic             tick;
   logic             e_q, e_qq, m_q, m_qq;
   logic [3:0]       pend, set, gnt, dec;
   logic [1:0]       ptr;
   logic [DW-1:0]    decae_cnt;
   logic             decae;
   logic [3:0][1:0]  nivel, nivel_d;
   logic             alerta_d;
   estado_t          estado;
   logic             serv_med;
   logic [W-1:0]     fase;
   logic [C5W-1:0]   cuenta5;

   divisor_tick #(
      .CICLOS_TICK (CICLOS_TICK),
      .TEST_DIV    (TEST_DIV)
   ) u_div (
      .clk     (clk),
      .rst     (Bot_Reset),
      .test    (Bot_Test),
      .periodo (periodo),
      .tick    (tick)
   );

   assign decae = tick && (decae_cnt == DW'(TICKS_DECAE - 1));
   assign dec   = decae ? (4'b0001 << ptr) : 4'b0000;

   // The button being served may not re-arm its own request mid-window.
   always_comb begin
      set = '0;
      set[IDX_ENERGIA]  = e_q & ~e_qq &
                          ~(estado == ATENCION_5S && !serv_med);
      set[IDX_MEDICINA] = m_q & ~m_qq &
                          ~(estado == ATENCION_5S && serv_med);
      set[IDX_DESCANSO] = tick & Entrada_Descanso;
      set[IDX_ANIMO]    = tick & Entrada_Animo;
   end

   always_comb begin
      gnt = '0;
      if (estado == CONCEDER) begin
         priority case (1'b1)
            pend[IDX_MEDICINA]: gnt[IDX_MEDICINA] = 1'b1;
            pend[IDX_ENERGIA]:  gnt[IDX_ENERGIA]  = 1'b1;
            pend[IDX_DESCANSO]: gnt[IDX_DESCANSO] = 1'b1;
            pend[IDX_ANIMO]:    gnt[IDX_ANIMO]    = 1'b1;
            default:            gnt = '0;
         endcase
      end
   end

   // Simultaneous grant and decay on one need cancel out.
   always_comb begin
      nivel_d  = nivel;
      alerta_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (gnt[i] && !dec[i] && nivel[i] != NIVEL_MAX)
            nivel_d[i] = nivel[i] + 2'd1;
         else if (dec[i] && !gnt[i] && nivel[i] != NIVEL_MIN)
            nivel_d[i] = nivel[i] - 2'd1;
         if (nivel_d[i] == NIVEL_MIN)
            alerta_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (Bot_Reset) begin
         e_q       <= 1'b0;
         e_qq      <= 1'b0;
         m_q       <= 1'b0;
         m_qq      <= 1'b0;
         pend      <= '0;
         ptr       <= '0;
         decae_cnt <= '0;
         nivel     <= {4{NIVEL_MAX}};
         Alerta    <= 1'b0;
      end else begin
         e_q    <= Bot_Energia;
         e_qq   <= e_q;
         m_q    <= Bot_Medicina;
         m_qq   <= m_q;
         pend   <= (pend | set) & ~gnt;
         nivel  <= nivel_d;
         Alerta <= alerta_d;
         if (decae) begin
            decae_cnt <= '0;
            ptr       <= ptr + 2'd1;
         end else if (tick) begin
            decae_cnt <= decae_cnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Bot_Reset) begin
         estado             <= REPOSO;
         serv_med           <= 1'b0;
         fase               <= '0;
         cuenta5            <= '0;
         senal_5segEnergia  <= 1'b0;
         senal_5segMedicina <= 1'b0;
      end else begin
         unique case (estado)
            REPOSO: begin
               if (|pend) estado <= CONCEDER;
            end
            CONCEDER: begin
               if (gnt[IDX_ENERGIA] || gnt[IDX_MEDICINA]) begin
                  estado             <= ATENCION_5S;
                  serv_med           <= gnt[IDX_MEDICINA];
                  senal_5segEnergia  <= gnt[IDX_ENERGIA];
                  senal_5segMedicina <= gnt[IDX_MEDICINA];
                  fase               <= '0;
                  cuenta5            <= '0;
               end else begin
                  estado <= REPOSO;
               end
            end
            ATENCION_5S: begin
               if (fase >= periodo - UNO) begin
                  fase <= '0;
                  if (cuenta5 == C5W'(TICKS_5S - 1)) begin
                     cuenta5            <= '0;
                     senal_5segEnergia  <= 1'b0;
                     senal_5segMedicina <= 1'b0;
                     estado             <= REPOSO;
                  end else begin
                     cuenta5 <= cuenta5 + C5W'(1);
                  end
               end else begin
                  fase <= fase + UNO;
               end
            end
            default: estado <= REPOSO;
         endcase
      end
   end

   assign Nivel_Animo    = nivel[IDX_ANIMO];
   assign Nivel_Energia  = nivel[IDX_ENERGIA];
   assign Nivel_Descanso = nivel[IDX_DESCANSO];
   assign Nivel_Medicina = nivel[IDX_MEDICINA];

endmodule

// File: tb/tb_planificador_necesidades.sv
// Bench for planificador_necesidades: timeline model plus directed literals.
// Build with or without MODO_TEST_EN; the tick-rate check adapts.
module tb_planificador_necesidades;

   localparam int CT = 4;
   localparam int TD = 2;
   localparam int T5 = 3;
   localparam int DV = 2;
`ifdef MODO_TEST_EN
   localparam int TEST_ON = 1;
`else
   localparam int TEST_ON = 0;
`endif

   logic clk = 1'b0;
   logic Bot_Reset = 1'b0, Bot_Test = 1'b0;
   logic Bot_Energia = 1'b0, Bot_Medicina = 1'b0;
   logic Entrada_Descanso = 1'b0, Entrada_Animo = 1'b0;
   logic [1:0] Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina;
   logic senal_5segEnergia, senal_5segMedicina, Alerta;

   planificador_necesidades #(
      .CICLOS_TICK (CT),
      .TICKS_DECAE (TD),
      .TICKS_5S    (T5),
      .TEST_DIV    (DV)
   ) dut (
      .clk                (clk),
      .Bot_Reset          (Bot_Reset),
      .Bot_Test           (Bot_Test),
      .Bot_Energia        (Bot_Energia),
      .Bot_Medicina       (Bot_Medicina),
      .Entrada_Descanso   (Entrada_Descanso),
      .Entrada_Animo      (Entrada_Animo),
      .Nivel_Animo        (Nivel_Animo),
      .Nivel_Energia      (Nivel_Energia),
      .Nivel_Descanso     (Nivel_Descanso),
      .Nivel_Medicina     (Nivel_Medicina),
      .senal_5segEnergia  (senal_5segEnergia),
      .senal_5segMedicina (senal_5segMedicina),
      .Alerta             (Alerta)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int nprint = 0;
   int k_rel = 0;
   bit model_on = 1'b1;

   // Timeline model: t counts clock edges since the reset edge.
   int m_lvl [4];
   bit m_pend [4];
   bit se1, se2, sm1, sm2;
   int m_t, m_grant_at, m_free, m_g, m_end, m_serv;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      if (Bot_Reset) begin
         for (int i = 0; i < 4; i++) begin
            m_lvl[i] = 3;
            m_pend[i] = 1'b0;
         end
         se1 = 0; se2 = 0; sm1 = 0; sm2 = 0;
         m_t = 0; m_grant_at = -1; m_free = 1;
         m_g = 0; m_end = 0; m_serv = -1;
         m_valid = 1'b1;
      end else if (m_valid) begin
         int inc, dcy;
         bit tk, re, rm, any;
         m_t++;
         tk = (m_t % CT == 0);
         dcy = (tk && (m_t % (CT * TD) == 0)) ?
               ((m_t / (CT * TD)) - 1) % 4 : -1;
         re = se1 && !se2;
         rm = sm1 && !sm2;
         se2 = se1; se1 = Bot_Energia;
         sm2 = sm1; sm1 = Bot_Medicina;
         if (m_serv >= 0 && m_t > m_g && m_t <= m_end) begin
            if (m_serv == 1) re = 0;
            else rm = 0;
         end
         any = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
         inc = -1;
         if (m_grant_at == m_t) begin
            if (m_pend[3]) inc = 3;
            else if (m_pend[1]) inc = 1;
            else if (m_pend[2]) inc = 2;
            else inc = 0;
            m_grant_at = -1;
            if (inc == 1 || inc == 3) begin
               m_serv = inc; m_g = m_t;
               m_end = m_t + CT * T5;
               m_free = m_end + 1;
            end else begin
               m_free = m_t + 1;
            end
         end else if (m_grant_at < 0 && m_t >= m_free && any) begin
            m_grant_at = m_t + 1;
         end
         if (re) m_pend[1] = 1'b1;
         if (rm) m_pend[3] = 1'b1;
         if (tk && Entrada_Descanso) m_pend[2] = 1'b1;
         if (tk && Entrada_Animo) m_pend[0] = 1'b1;
         if (inc >= 0) m_pend[inc] = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (i == inc && i != dcy && m_lvl[i] < 3) m_lvl[i]++;
            else if (i == dcy && i != inc && m_lvl[i] > 0) m_lvl[i]--;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid && model_on) begin
         logic [10:0] got, exp;
         logic ex_se, ex_sm, ex_al;
         ex_se = (m_serv == 1) && (m_t >= m_g) && (m_t < m_end);
         ex_sm = (m_serv == 3) && (m_t >= m_g) && (m_t < m_end);
         ex_al = (m_lvl[0] == 0) || (m_lvl[1] == 0) ||
                 (m_lvl[2] == 0) || (m_lvl[3] == 0);
         got = {Nivel_Animo, Nivel_Energia, Nivel_Descanso,
                Nivel_Medicina, senal_5segEnergia,
                senal_5segMedicina, Alerta};
         exp = {2'(m_lvl[0]), 2'(m_lvl[1]), 2'(m_lvl[2]),
                2'(m_lvl[3]), ex_se, ex_sm, ex_al};
         checks++;
         if (got !== exp) begin
            failures++;
            if (nprint < 20) begin
               nprint++;
               $display("FAIL model t=%0d got=%b exp=%b", m_t, got, exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic reiniciar();
      Bot_Reset = 1'b1;
      @(posedge clk);
      #1;
      Bot_Reset = 1'b0;
      k_rel = 0;
   endtask

   task automatic hasta(input int obj);
      if (k_rel < obj) begin
         repeat (obj - k_rel) @(posedge clk);
         #1;
         k_rel = obj;
      end
   endtask

   int altos;

   initial begin
      #2;
      // Idle decay and single Energia request
      reiniciar();
      chk("reset_animo", 8'(Nivel_Animo), 8'd3);
      chk("reset_medicina", 8'(Nivel_Medicina), 8'd3);
      chk("reset_alerta", 8'(Alerta), 8'd0);
      hasta(64);
      chk("decay_animo", 8'(Nivel_Animo), 8'd1);
      chk("decay_energia", 8'(Nivel_Energia), 8'd1);
      chk("decay_descanso", 8'(Nivel_Descanso), 8'd1);
      chk("decay_medicina", 8'(Nivel_Medicina), 8'd1);
      chk("decay_alerta", 8'(Alerta), 8'd0);
      Bot_Energia = 1'b1;
      hasta(66);
      Bot_Energia = 1'b0;
      hasta(67);
      chk("lat_energia_n2", 8'(Nivel_Energia), 8'd1);
      chk("lat_senal_n2", 8'(senal_5segEnergia), 8'd0);
      hasta(68);
      chk("lat_energia_n3", 8'(Nivel_Energia), 8'd2);
      altos = 0;
      for (int e = 68; e <= 84; e++) begin
         hasta(e);
         if (e == 71) Bot_Energia = 1'b1;
         if (e == 73) Bot_Energia = 1'b0;
         if (senal_5segEnergia === 1'b1) altos++;
      end
      chk("senal_energia_ciclos", 8'(altos), 8'd12);
      chk("repress_ignorado", 8'(Nivel_Energia), 8'd1);
      chk("animo_cero", 8'(Nivel_Animo), 8'd0);
      chk("alerta_sube", 8'(Alerta), 8'd1);

      // Simultaneous Medicina and Energia
      reiniciar();
      hasta(32);
      chk("pre_medicina", 8'(Nivel_Medicina), 8'd2);
      Bot_Energia = 1'b1;
      Bot_Medicina = 1'b1;
      hasta(34);
      Bot_Energia = 1'b0;
      Bot_Medicina = 1'b0;
      hasta(36);
      chk("prio_medicina", 8'(Nivel_Medicina), 8'd3);
      chk("prio_energia_espera", 8'(Nivel_Energia), 8'd2);
      chk("prio_senal_m", 8'(senal_5segMedicina), 8'd1);
      chk("prio_senal_e", 8'(senal_5segEnergia), 8'd0);
      hasta(48);
      chk("fin_ventana_m", 8'(senal_5segMedicina), 8'd0);
      hasta(50);
      chk("energia_despues", 8'(Nivel_Energia), 8'd2);
      chk("senal_e_despues", 8'(senal_5segEnergia), 8'd1);

      // Animo saturation, drain to zero, sensor refill
      reiniciar();
      Entrada_Animo = 1'b1;
      hasta(4);
      Entrada_Animo = 1'b0;
      hasta(7);
      chk("animo_satura", 8'(Nivel_Animo), 8'd3);
      hasta(72);
      chk("animo_drenado", 8'(Nivel_Animo), 8'd0);
      chk("alerta_drenado", 8'(Alerta), 8'd1);
      hasta(73);
      Entrada_Animo = 1'b1;
      hasta(76);
      Entrada_Animo = 1'b0;
      hasta(77);
      chk("animo_espera_tick", 8'(Nivel_Animo), 8'd0);
      hasta(78);
      chk("animo_sube", 8'(Nivel_Animo), 8'd1);
      chk("alerta_baja", 8'(Alerta), 8'd0);

      // Reset aborts an attention window
      reiniciar();
      hasta(32);
      Bot_Energia = 1'b1;
      hasta(33);
      Bot_Energia = 1'b0;
      hasta(36);
      chk("ventana_activa", 8'(senal_5segEnergia), 8'd1);
      hasta(40);
      reiniciar();
      chk("abort_senal", 8'(senal_5segEnergia), 8'd0);
      chk("abort_animo", 8'(Nivel_Animo), 8'd3);
      chk("abort_descanso", 8'(Nivel_Descanso), 8'd3);
      Bot_Medicina = 1'b1;
      hasta(1);
      Bot_Medicina = 1'b0;
      hasta(3);
      chk("reposo_tras_reset_n2", 8'(senal_5segMedicina), 8'd0);
      hasta(4);
      chk("reposo_tras_reset_n3", 8'(senal_5segMedicina), 8'd1);

      // Tick rate with Bot_Test held
      model_on = 1'b0;
      Bot_Test = 1'b1;
      reiniciar();
      hasta(4);
      chk("test_animo_t4", 8'(Nivel_Animo), TEST_ON ? 8'd2 : 8'd3);
      hasta(8);
      chk("test_energia_t8", 8'(Nivel_Energia), TEST_ON ? 8'd2 : 8'd3);
      chk("test_animo_t8", 8'(Nivel_Animo), 8'd2);
      Bot_Test = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
